// File: rtl/mux_tree16.sv
// mux_tree16: 16:1 selector built as a mux2/mux4 tree, with a registered copy of the result.
// Latency: mux_out is combinational (0 cycles); mux_out_q/sel_q update 1 cycle after an enabled edge.
// Backpressure: none; en gates the output register, and a deasserted en holds the last value.
//
// Ports:
//   clk        - clock; all register updates on its rising edge
//   reset      - synchronous active-high clear of mux_out_q and sel_q (no effect on mux_out)
//   mux_in0..15- BUS_WIDTH-bit data candidates
//   sel        - 4-bit binary index of the selected candidate
//   en         - load enable for mux_out_q/sel_q
//   mux_out    - combinational selection mux_in[sel]
//   mux_out_q  - registered selection
//   sel_q      - sel captured together with mux_out_q

// Leaf cell: out = s ? in1 : in0
module mux_tree16_mux2 #(
  parameter int W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         s,
  output logic [W-1:0] out
);
  assign out = s ? in1 : in0;
endmodule

// 4:1 from three mux2 cells: s[0] picks within each pair, s[1] between pairs.
module mux_tree16_mux4 #(
  parameter int W = 4
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [1:0]   s,
  output logic [W-1:0] out
);
  logic [W-1:0] lo;
  logic [W-1:0] hi;

  mux_tree16_mux2 #(.W(W)) u_lo  (.in0(in0), .in1(in1), .s(s[0]), .out(lo));
  mux_tree16_mux2 #(.W(W)) u_hi  (.in0(in2), .in1(in3), .s(s[0]), .out(hi));
  mux_tree16_mux2 #(.W(W)) u_top (.in0(lo),  .in1(hi),  .s(s[1]), .out(out));
endmodule

// 16:1 from five mux4 cells. Candidate i sits at bits [i*W +: W] of din.
module mux_tree16_mux16 #(
  parameter int W = 4
) (
  input  logic [16*W-1:0] din,
  input  logic [3:0]      s,
  output logic [W-1:0]    out
);
  logic [W-1:0] grp [4];

  // First level: group g covers candidates 4g..4g+3, indexed by s[1:0].
  for (genvar g = 0; g < 4; g++) begin : g_lvl1
    mux_tree16_mux4 #(.W(W)) u_m4 (
      .in0(din[(4*g+0)*W +: W]),
      .in1(din[(4*g+1)*W +: W]),
      .in2(din[(4*g+2)*W +: W]),
      .in3(din[(4*g+3)*W +: W]),
      .s  (s[1:0]),
      .out(grp[g])
    );
  end

  // Second level picks the group with s[3:2].
  mux_tree16_mux4 #(.W(W)) u_lvl2 (
    .in0(grp[0]),
    .in1(grp[1]),
    .in2(grp[2]),
    .in3(grp[3]),
    .s  (s[3:2]),
    .out(out)
  );
endmodule

module mux_tree16 #(
  parameter int BUS_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BUS_WIDTH-1:0] mux_in0,
  input  logic [BUS_WIDTH-1:0] mux_in1,
  input  logic [BUS_WIDTH-1:0] mux_in2,
  input  logic [BUS_WIDTH-1:0] mux_in3,
  input  logic [BUS_WIDTH-1:0] mux_in4,
  input  logic [BUS_WIDTH-1:0] mux_in5,
  input  logic [BUS_WIDTH-1:0] mux_in6,
  input  logic [BUS_WIDTH-1:0] mux_in7,
  input  logic [BUS_WIDTH-1:0] mux_in8,
  input  logic [BUS_WIDTH-1:0] mux_in9,
  input  logic [BUS_WIDTH-1:0] mux_in10,
  input  logic [BUS_WIDTH-1:0] mux_in11,
  input  logic [BUS_WIDTH-1:0] mux_in12,
  input  logic [BUS_WIDTH-1:0] mux_in13,
  input  logic [BUS_WIDTH-1:0] mux_in14,
  input  logic [BUS_WIDTH-1:0] mux_in15,
  input  logic [3:0]           sel,
  input  logic                 en,
  output logic [BUS_WIDTH-1:0] mux_out,
  output logic [BUS_WIDTH-1:0] mux_out_q,
  output logic [3:0]           sel_q
);
  // Candidate 0 lands in the least-significant slice, so sel maps directly to the slice index.
  logic [16*BUS_WIDTH-1:0] din;

  assign din = {mux_in15, mux_in14, mux_in13, mux_in12,
                mux_in11, mux_in10, mux_in9,  mux_in8,
                mux_in7,  mux_in6,  mux_in5,  mux_in4,
                mux_in3,  mux_in2,  mux_in1,  mux_in0};

  mux_tree16_mux16 #(.W(BUS_WIDTH)) u_tree (
    .din(din),
    .s  (sel),
    .out(mux_out)
  );

  // Reset takes priority over en; there is deliberately no asynchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_out_q <= '0;
      sel_q     <= '0;
    end else if (en) begin
      mux_out_q <= mux_out;
      sel_q     <= sel;
    end
  end
endmodule

// File: tb/tb_mux_tree16.sv
// tb_mux_tree16: directed checks of mux_tree16 at BUS_WIDTH=4 and BUS_WIDTH=1.
// Latency: outputs sampled 1 time unit after stimulus / after the rising edge.
// Backpressure: not applicable.
module tb_mux_tree16;
  logic       clk;
  logic       reset;
  logic       en;
  logic [3:0] sel;
  logic [3:0] din [16];
  logic [3:0] mux_out;
  logic [3:0] mux_out_q;
  logic [3:0] sel_q;

  logic [3:0] sel1;
  logic       din1 [16];
  logic       mux_out1;
  logic       mux_out_q1;
  logic [3:0] sel_q1;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux_tree16 #(.BUS_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .mux_in0(din[0]),   .mux_in1(din[1]),   .mux_in2(din[2]),   .mux_in3(din[3]),
    .mux_in4(din[4]),   .mux_in5(din[5]),   .mux_in6(din[6]),   .mux_in7(din[7]),
    .mux_in8(din[8]),   .mux_in9(din[9]),   .mux_in10(din[10]), .mux_in11(din[11]),
    .mux_in12(din[12]), .mux_in13(din[13]), .mux_in14(din[14]), .mux_in15(din[15]),
    .sel(sel), .en(en),
    .mux_out(mux_out), .mux_out_q(mux_out_q), .sel_q(sel_q)
  );

  mux_tree16 #(.BUS_WIDTH(1)) dut_w1 (
    .clk(clk), .reset(reset),
    .mux_in0(din1[0]),   .mux_in1(din1[1]),   .mux_in2(din1[2]),   .mux_in3(din1[3]),
    .mux_in4(din1[4]),   .mux_in5(din1[5]),   .mux_in6(din1[6]),   .mux_in7(din1[7]),
    .mux_in8(din1[8]),   .mux_in9(din1[9]),   .mux_in10(din1[10]), .mux_in11(din1[11]),
    .mux_in12(din1[12]), .mux_in13(din1[13]), .mux_in14(din1[14]), .mux_in15(din1[15]),
    .sel(sel1), .en(en),
    .mux_out(mux_out1), .mux_out_q(mux_out_q1), .sel_q(sel_q1)
  );

  // Hold reset for two edges with en=1, sel=7; registers clear, comb path still selects.
  task automatic test_reset();
    reset = 1'b1; en = 1'b1; sel = 4'd7; sel1 = 4'd1;
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (mux_out_q !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0h want 0", mux_out_q); end
    n_checks++; if (sel_q !== 4'd0) begin n_fail++; $display("FAIL reset_sel_q: got %0h want 0", sel_q); end
    n_checks++; if (mux_out !== 4'd7) begin n_fail++; $display("FAIL reset_comb: got %0h want 7", mux_out); end
    n_checks++; if (mux_out_q1 !== 1'b0) begin n_fail++; $display("FAIL reset_q_w1: got %0b want 0", mux_out_q1); end
    n_checks++; if (sel_q1 !== 4'd0) begin n_fail++; $display("FAIL reset_sel_q_w1: got %0h want 0", sel_q1); end
  endtask

  // With mux_in_i = i, mux_out must equal sel at every step.
  task automatic test_sweep();
    for (int i = 0; i < 16; i++) begin
      sel = 4'(i);
      #1;
      n_checks++;
      if (mux_out !== 4'(i)) begin n_fail++; $display("FAIL sweep sel=%0d: got %0h want %0h", i, mux_out, i); end
      #9;
    end
  endtask

  // Load on enabled edge, then hold with en=0 while the comb path follows sel.
  task automatic test_load_hold();
    @(negedge clk);
    reset = 1'b0; en = 1'b1; sel = 4'd9;
    @(posedge clk); #1;
    n_checks++; if (mux_out_q !== 4'd9) begin n_fail++; $display("FAIL load_q: got %0h want 9", mux_out_q); end
    n_checks++; if (sel_q !== 4'd9) begin n_fail++; $display("FAIL load_sel_q: got %0h want 9", sel_q); end
    en = 1'b0; sel = 4'd3;
    @(posedge clk); #1;
    n_checks++; if (mux_out !== 4'd3) begin n_fail++; $display("FAIL hold_comb: got %0h want 3", mux_out); end
    n_checks++; if (mux_out_q !== 4'd9) begin n_fail++; $display("FAIL hold_q: got %0h want 9", mux_out_q); end
    n_checks++; if (sel_q !== 4'd9) begin n_fail++; $display("FAIL hold_sel_q: got %0h want 9", sel_q); end
  endtask

  // 1-bit instance: in0=0, in1=1, others 0; toggle sel.
  task automatic test_width1();
    logic exp [4];
    logic [3:0] s_seq [4];
    s_seq[0] = 4'd0; s_seq[1] = 4'd1; s_seq[2] = 4'd0; s_seq[3] = 4'd1;
    exp[0] = 1'b0;   exp[1] = 1'b1;   exp[2] = 1'b0;   exp[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel1 = s_seq[i];
      #1;
      n_checks++;
      if (mux_out1 !== exp[i]) begin n_fail++; $display("FAIL width1 step %0d: got %0b want %0b", i, mux_out1, exp[i]); end
      #9;
    end
  endtask

  // Neighbours of the selected input must not leak; the selected one propagates at once.
  task automatic test_unselected();
    sel = 4'd5;
    #1;
    din[4] = 4'hF; din[6] = 4'hC;
    #1;
    n_checks++; if (mux_out !== 4'd5) begin n_fail++; $display("FAIL unsel_neighbours: got %0h want 5", mux_out); end
    din[5] = 4'hA;
    #1;
    n_checks++; if (mux_out !== 4'hA) begin n_fail++; $display("FAIL unsel_selected: got %0h want a", mux_out); end
    // Comb change between edges must not reach the register while en=0.
    n_checks++; if (mux_out_q !== 4'd9) begin n_fail++; $display("FAIL unsel_q_stable: got %0h want 9", mux_out_q); end
    din[4] = 4'd4; din[5] = 4'd5; din[6] = 4'd6;
  endtask

  // Register tracks a new sel on every enabled edge.
  task automatic test_back_to_back();
    logic [3:0] s_seq [4];
    s_seq[0] = 4'd2; s_seq[1] = 4'd14; s_seq[2] = 4'd0; s_seq[3] = 4'd11;
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = s_seq[i];
      @(posedge clk); #1;
      n_checks++;
      if (mux_out_q !== s_seq[i]) begin n_fail++; $display("FAIL b2b_q step %0d: got %0h want %0h", i, mux_out_q, s_seq[i]); end
      n_checks++;
      if (sel_q !== s_seq[i]) begin n_fail++; $display("FAIL b2b_sel_q step %0d: got %0h want %0h", i, sel_q, s_seq[i]); end
    end
  endtask

  // Reset and en on the same edge: reset wins; next enabled edge loads normally.
  task automatic test_reset_priority();
    @(negedge clk);
    reset = 1'b1; en = 1'b1; sel = 4'd15;
    @(posedge clk); #1;
    n_checks++; if (mux_out_q !== 4'd0) begin n_fail++; $display("FAIL rst_prio_q: got %0h want 0", mux_out_q); end
    n_checks++; if (sel_q !== 4'd0) begin n_fail++; $display("FAIL rst_prio_sel_q: got %0h want 0", sel_q); end
    n_checks++; if (mux_out !== 4'd15) begin n_fail++; $display("FAIL rst_prio_comb: got %0h want f", mux_out); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (mux_out_q !== 4'd15) begin n_fail++; $display("FAIL rst_release_q: got %0h want f", mux_out_q); end
    n_checks++; if (sel_q !== 4'd15) begin n_fail++; $display("FAIL rst_release_sel_q: got %0h want f", sel_q); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; en = 1'b0; sel = 4'd0; sel1 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      din[i]  = 4'(i);
      din1[i] = (i == 1);
    end

    test_reset();
    test_sweep();
    test_load_hold();
    test_width1();
    test_unselected();
    test_back_to_back();
    test_reset_priority();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_tree16.md
MUX_TREE16 -- requirements
Module: mux_tree16

Interface
REQ-001 The module SHALL have parameter BUS_WIDTH, default 4, giving the width of every data input and output in bits (legal range 1..64).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 The module SHALL have ports mux_in0..mux_in15, input, BUS_WIDTH bits each: the sixteen data candidates.
REQ-005 The module SHALL have port sel, input, 4 bits: the index of the selected candidate.
REQ-006 The module SHALL have port en, input, 1 bit: load enable for the output register.
REQ-007 The module SHALL have port mux_out, output, BUS_WIDTH bits: the combinational selection.
REQ-008 The module SHALL have port mux_out_q, output, BUS_WIDTH bits: the registered selection.
REQ-009 The module SHALL have port sel_q, output, 4 bits: the registered copy of sel captured with mux_out_q.

Function
REQ-010 The module SHALL drive mux_out = mux_in[sel] for every sel in 0..15, with zero clock latency (purely combinational).
REQ-011 mux_out SHALL be built as a tree of leaf mux2 cells (out = s ? in1 : in0).
REQ-012 Each mux4 stage SHALL be composed from three mux2 cells: sel bit 0 picks within each pair, sel bit 1 picks between the pair results.
REQ-013 The mux16 stage SHALL be composed from five mux4 cells: four first-level cells with sel[1:0], one second-level cell with sel[3:2].
REQ-014 Index mapping SHALL be binary: sel=0 selects mux_in0, and sel=15 selects mux_in15.
REQ-015 mux_out SHALL be independent of clk, reset and en.
REQ-016 On a rising clk edge with reset=0 and en=1, mux_out_q SHALL load mux_out and sel_q SHALL load sel (latency 1 cycle).
REQ-017 On a rising clk edge with reset=0 and en=0, mux_out_q and sel_q SHALL hold their values.
REQ-018 A change of sel or of any data input between edges SHALL affect mux_out immediately and mux_out_q only at the next enabled edge.
REQ-019 An X or Z on any sel bit SHALL not be required to give a defined output; with a known sel, unselected inputs SHALL not affect mux_out.
REQ-020 All outputs SHALL be full BUS_WIDTH with no truncation or sign extension.

Reset
REQ-021 On a rising clk edge with reset=1, mux_out_q SHALL become all zeros and sel_q SHALL become 0, regardless of en.
REQ-022 Reset SHALL have no effect on mux_out.
REQ-023 Reset asserted mid-operation SHALL clear the registers at that edge; the first enabled edge after reset deasserts SHALL load normally.
REQ-024 The registers SHALL have no asynchronous reset path.

Verification
REQ-025 Scenario: BUS_WIDTH=4, mux_in_i = i, sweep sel 0..15 with 10 time units per step -> mux_out = sel at every step.
REQ-026 Scenario: hold reset=1 for 2 edges with en=1 and sel=7 -> mux_out_q=0, sel_q=0, mux_out=7.
REQ-027 Scenario: reset=0, en=1, sel=9, then one edge -> mux_out_q=9, sel_q=9; then set en=0, sel=3, one edge -> mux_out=3, mux_out_q=9 still.
REQ-028 Scenario: BUS_WIDTH=1, mux_in0=0, mux_in1=1, all other inputs=0, toggle sel between 0 and 1 -> mux_out follows 0, 1.
REQ-029 Scenario: sel=5, change only mux_in4 and mux_in6 -> mux_out unchanged; change mux_in5 to 0xA -> mux_out=0xA immediately.
REQ-030 Scenario: reset=1 and en=1 on the same edge, sel=15 -> mux_out_q=0 (reset wins); on the next edge with reset=0 -> mux_out_q=15.
